// File: rtl/lsu_rmw.sv
// rtl/lsu_rmw.sv - load/store alignment unit with sub-word read-modify-write
module lsu_rmw #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  logic             req_wr,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             stall,
    output logic [31:0]      ld_data,
    output logic             ld_valid,
    output logic             misalign,
    output logic             illegal,
    output logic [31:0]      mem_ad,
    output logic [31:0]      mem_wrtDat,
    output logic             mem_memWrt,
    input  logic [31:0]      mem_redDat,
    output logic [CNT_W-1:0] rmw_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] merge_q;
    logic [31:0] addr_q;
    logic [31:0] merged;
    logic [31:0] word_ad;
    logic        legal;
    logic        mis;
    logic        capture;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign word_ad = {req_addr[31:2], 2'b00};

    // Decode legality, alignment, lane extraction and the merged store word
    always_comb begin
        legal = 1'b0;
        if (req_wr) begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
        end else begin
            legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                    (req_funct3 == 3'b100) || (req_funct3 == 3'b101);
        end

        mis = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        byte_lane = mem_redDat[7:0];
        case (req_addr[1:0])
            2'b00: byte_lane = mem_redDat[7:0];
            2'b01: byte_lane = mem_redDat[15:8];
            2'b10: byte_lane = mem_redDat[23:16];
            2'b11: byte_lane = mem_redDat[31:24];
            default: byte_lane = mem_redDat[7:0];
        endcase
        half_lane = req_addr[1] ? mem_redDat[31:16] : mem_redDat[15:0];

        merged = mem_redDat;
        if (req_funct3[1:0] == 2'b00) begin
            case (req_addr[1:0])
                2'b00: merged[7:0]   = req_wdata[7:0];
                2'b01: merged[15:8]  = req_wdata[7:0];
                2'b10: merged[23:16] = req_wdata[7:0];
                2'b11: merged[31:24] = req_wdata[7:0];
                default: merged[7:0] = req_wdata[7:0];
            endcase
        end else if (req_addr[1]) begin
            merged[31:16] = req_wdata[15:0];
        end else begin
            merged[15:0] = req_wdata[15:0];
        end
    end

    // Next-state and memory/pipeline strobes; reset masks every strobe
    always_comb begin
        state_nxt  = state;
        stall      = 1'b0;
        ld_data    = 32'h0;
        ld_valid   = 1'b0;
        misalign   = 1'b0;
        illegal    = 1'b0;
        mem_ad     = word_ad;
        mem_wrtDat = req_wdata;
        mem_memWrt = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (!legal) begin
                        illegal = 1'b1;
                    end else if (mis) begin
                        misalign = 1'b1;
                    end else if (!req_wr) begin
                        ld_valid = 1'b1;
                        case (req_funct3)
                            3'b000:  ld_data = {{24{byte_lane[7]}}, byte_lane};
                            3'b001:  ld_data = {{16{half_lane[15]}}, half_lane};
                            3'b100:  ld_data = {24'h0, byte_lane};
                            3'b101:  ld_data = {16'h0, half_lane};
                            default: ld_data = mem_redDat;
                        endcase
                    end else if (req_funct3 == 3'b010) begin
                        mem_memWrt = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        capture   = 1'b1;
                        state_nxt = WRITE;
                    end
                end
            end
            WRITE: begin
                // Request inputs still show the held store; only the registers matter here
                mem_ad     = addr_q;
                mem_wrtDat = merge_q;
                mem_memWrt = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            stall      = 1'b0;
            mem_memWrt = 1'b0;
            ld_valid   = 1'b0;
            misalign   = 1'b0;
            illegal    = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture merged word and word address in the read cycle of a sub-word store
    always_ff @(posedge clk) begin
        if (rst) begin
            merge_q <= 32'h0;
            addr_q  <= 32'h0;
        end else if (capture) begin
            merge_q <= merged;
            addr_q  <= word_ad;
        end
    end

    // Count sub-word stores as their write cycle completes; wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            rmw_count <= '0;
        end else if (state == WRITE) begin
            rmw_count <= rmw_count + CNT_W'(1);
        end
    end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store alignment unit in the MEM stage of the in-order pipeline, placed directly upstream of the word-addressed data memory. Converts RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW requests into word accesses. Sign- or zero-extends load results. Executes byte and halfword stores as a two-cycle read-modify-write, stalling the pipeline for one cycle.

## Interface
- CNT_W, default 32: width of the completed-RMW performance counter.
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage holds a memory op this cycle.
- req_wr  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rs2).
- stall  out  1  hold IF/ID/EX/MEM registers this cycle.
- ld_data  out  32  extended load result for writeback.
- ld_valid  out  1  ld_data is valid this cycle.
- misalign  out  1  access not naturally aligned; op dropped.
- illegal  out  1  funct3 not legal for the op; op dropped.
- mem_ad  out  32  word address to data memory; bits [1:0] always 0.
- mem_wrtDat  out  32  full word to write.
- mem_memWrt  out  1  write enable to data memory.
- mem_redDat  in  32  combinational read data from data memory at mem_ad.
- rmw_count  out  CNT_W  number of completed sub-word stores.

## Operation
- States: IDLE, WRITE.
- Legal funct3 values:
  - Loads: 000, 001, 010, 100, 101.
  - Stores: 000, 001, 010.
  - Any other value: illegal=1, no access, no state change.
- Alignment rules:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]≠0 is misaligned.
  - A misaligned op gives misalign=1, memWrt=0, ld_valid=0, and no state change.
- Load (IDLE):
  - mem_ad = {addr[31:2],2'b00}.
  - Lane select: byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend the selected lane. BU/HU zero-extend it. W passes the word through.
  - ld_valid=1, stall=0.
- SW (IDLE): mem_wrtDat=req_wdata, memWrt=1, stall=0. Stays in IDLE.
- SB/SH, first cycle (IDLE):
  - Drive mem_ad.
  - Register the merged word: mem_redDat with the selected lane replaced by wdata[7:0] or wdata[15:0].
  - Register the word address.
  - stall=1, memWrt=0. Go to WRITE.
- SB/SH, second cycle (WRITE):
  - mem_ad and mem_wrtDat come from the registers.
  - memWrt=1, stall=0.
  - The request inputs (still the same store, held by the stall) are ignored.
  - rmw_count increments at the clock edge. Go to IDLE.
- rmw_count wraps modulo 2^CNT_W.
- With req_valid=0 in IDLE, all strobes are 0 and ld_data=0.
- Reset values:
  - State IDLE, rmw_count 0, merge registers 0.
  - While rst is high, stall, memWrt, ld_valid, misalign and illegal are forced to 0.
  - Reset asserted in WRITE aborts the store: no write occurs.

## Timing
- Loads: 0-cycle latency; ld_data is combinational from mem_redDat in the same cycle.
- SW: 1 cycle, written at the closing posedge.
- SB/SH: exactly 2 cycles. stall is high only in the first; the write happens at the posedge ending WRITE.
- The pipeline keeps req_* stable while stall=1.
- Back-to-back ops: a load in the cycle after any store returns the updated word.
- misalign and illegal are combinational single-cycle strobes.
- The stage is never stalled by them; the trap handling is owned downstream.

## Test plan
- Reset, then SW addr 0x10 data 0xDEADBEEF; next cycle LW 0x10 → ld_data 0xDEADBEEF, no stall, rmw_count 0.
- After the above: LB 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x10 → 0xFFFFBEEF; LHU 0x12 → 0x0000DEAD.
- SB 0x11 data 0x00000055 over word 0xDEADBEEF → stall=1 for 1 cycle, memWrt only in the second cycle, word becomes 0xDEAD55EF, rmw_count 1. Then SH 0x12 data 0x1234 → word 0x123455EF, rmw_count 2.
- LW 0x12, SH 0x11, LH 0x03 → misalign=1 each, memWrt=0, ld_valid=0, memory unchanged. Store with funct3=100 → illegal=1, no write.
- Assert rst in the WRITE cycle of SB 0x20 data 0xAA → no write (word stays 0), state IDLE, stall=0, rmw_count 0.
- Force rmw_count to 2^CNT_W−1 (CNT_W=4: 15), then run one SB → rmw_count wraps to 0.
